// File: rtl/sd_pkg.sv
// Shared types and constants for the signed-digit slice datapath.
package sd_pkg;

    localparam int CARRY_W = 2;
    localparam int SLICE_W = 4;

    localparam logic [CARRY_W-1:0] SD_ZERO_CARRY = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sched_state_t;

    // Value of one {plus,minus} digit or carry pair: -1, 0 or +1.
    function automatic logic signed [3:0] sd_digit(input logic p, input logic m);
        return $signed({3'b000, p}) - $signed({3'b000, m});
    endfunction

endpackage

// File: rtl/sd_slice_add3.sv
// Combinational 4-digit, three-operand signed-digit slice adder with two
// chained carry pairs; output digits are always canonical (never 11).
module sd_slice_add3
    import sd_pkg::*;
(
    input  logic [SLICE_W-1:0] a_plus,
    input  logic [SLICE_W-1:0] a_minus,
    input  logic [SLICE_W-1:0] b_plus,
    input  logic [SLICE_W-1:0] b_minus,
    input  logic [SLICE_W-1:0] r_plus,
    input  logic [SLICE_W-1:0] r_minus,
    input  logic [CARRY_W-1:0] cin_one,
    input  logic [CARRY_W-1:0] cin_two,
    output logic [SLICE_W-1:0] s_plus,
    output logic [SLICE_W-1:0] s_minus,
    output logic [CARRY_W-1:0] cout_one,
    output logic [CARRY_W-1:0] cout_two
);

    logic signed [3:0] u, w, v, z, d, t1, t2, n1, n2;

    // NOTE: blocking assignments here are intentional; t1/t2 ripple digit to digit within one evaluation.
    always_comb begin
        s_plus  = '0;
        s_minus = '0;
        u = '0; w = '0; v = '0; z = '0; d = '0; n1 = '0; n2 = '0;
        t1 = sd_digit(cin_one[1], cin_one[0]);
        t2 = sd_digit(cin_two[1], cin_two[0]);
        for (int i = 0; i < SLICE_W; i++) begin
            // Stage one: digit sum in [-3,3] -> 2*n1 + w with w in [-1,1].
            u = sd_digit(a_plus[i], a_minus[i]) + sd_digit(b_plus[i], b_minus[i])
              + sd_digit(r_plus[i], r_minus[i]);
            if (u >= 4'sd2)       n1 = 4'sd1;
            else if (u <= -4'sd2) n1 = -4'sd1;
            else                  n1 = 4'sd0;
            w  = u - n1 - n1;
            v  = w + t1;
            t1 = n1;
            // Stage two: pick z so that z + incoming carry stays a single digit.
            if (t2 >= 4'sd0) begin
                if (v >= 4'sd1)       n2 = 4'sd1;
                else if (v <= -4'sd2) n2 = -4'sd1;
                else                  n2 = 4'sd0;
            end else begin
                if (v >= 4'sd2)       n2 = 4'sd1;
                else if (v <= -4'sd1) n2 = -4'sd1;
                else                  n2 = 4'sd0;
            end
            z  = v - n2 - n2;
            d  = z + t2;
            t2 = n2;
            s_plus[i]  = (d == 4'sd1);
            s_minus[i] = (d == -4'sd1);
        end
        cout_one = {t1 == 4'sd1, t1 == -4'sd1};
        cout_two = {t2 == 4'sd1, t2 == -4'sd1};
    end

endmodule

// File: rtl/sd_slice_scheduler.sv
// Time-multiplexes one sd_slice_add3 across a wide redundant-binary word, LSB slice first.
// Optional: define SD_SCHED_CANCEL_EN to store 11 digits as 00 and present 11 carries as 00.
module sd_slice_scheduler
    import sd_pkg::*;
#(
    parameter  int SLICES = 4,
    localparam int W      = SLICES * SLICE_W,
    localparam int K_W    = (SLICES > 1) ? $clog2(SLICES) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W-1:0]       a_plus,
    input  logic [W-1:0]       a_minus,
    input  logic [W-1:0]       b_plus,
    input  logic [W-1:0]       b_minus,
    input  logic [W-1:0]       r_plus,
    input  logic [W-1:0]       r_minus,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W-1:0]       res_plus,
    output logic [W-1:0]       res_minus,
    output logic [CARRY_W-1:0] cout_one,
    output logic [CARRY_W-1:0] cout_two
);

    sched_state_t       state_q, state_d;
    logic [K_W-1:0]     k_q, k_d;
    logic [CARRY_W-1:0] c1_q, c1_d, c2_q, c2_d;
    logic [6*W-1:0]     ops_q, ops_d;
    logic [W-1:0]       res_plus_q, res_plus_d, res_minus_q, res_minus_d;
    logic [W-1:0]       op_ap, op_am, op_bp, op_bm, op_rp, op_rm;
    logic [SLICE_W-1:0] sum_p, sum_m, wr_p, wr_m;
    logic [CARRY_W-1:0] sl_c1, sl_c2;
    logic               accept, last_slice;

    assign in_ready   = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign accept     = in_valid && in_ready;
    assign last_slice = (k_q == K_W'(SLICES - 1));
    assign out_valid  = (state_q == ST_DONE);
    assign res_plus   = res_plus_q;
    assign res_minus  = res_minus_q;

    assign {op_ap, op_am, op_bp, op_bm, op_rp, op_rm} = ops_q;

    sd_slice_add3 u_add (
        .a_plus   (op_ap[k_q*SLICE_W +: SLICE_W]),
        .a_minus  (op_am[k_q*SLICE_W +: SLICE_W]),
        .b_plus   (op_bp[k_q*SLICE_W +: SLICE_W]),
        .b_minus  (op_bm[k_q*SLICE_W +: SLICE_W]),
        .r_plus   (op_rp[k_q*SLICE_W +: SLICE_W]),
        .r_minus  (op_rm[k_q*SLICE_W +: SLICE_W]),
        .cin_one  (c1_q),
        .cin_two  (c2_q),
        .s_plus   (sum_p),
        .s_minus  (sum_m),
        .cout_one (sl_c1),
        .cout_two (sl_c2)
    );

`ifdef SD_SCHED_CANCEL_EN
    assign wr_p     = sum_p & ~sum_m;
    assign wr_m     = sum_m & ~sum_p;
    assign cout_one = (c1_q == 2'b11) ? SD_ZERO_CARRY : c1_q;
    assign cout_two = (c2_q == 2'b11) ? SD_ZERO_CARRY : c2_q;
`else
    assign wr_p     = sum_p;
    assign wr_m     = sum_m;
    assign cout_one = c1_q;
    assign cout_two = c2_q;
`endif

    // NOTE: every _d gets a default first, so no path through the case can infer a latch.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        c1_d        = c1_q;
        c2_d        = c2_q;
        res_plus_d  = res_plus_q;
        res_minus_d = res_minus_q;
        ops_d       = accept ? {a_plus, a_minus, b_plus, b_minus, r_plus, r_minus} : ops_q;
        case (state_q)
            ST_IDLE: ;
            ST_RUN: begin
                res_plus_d[k_q*SLICE_W +: SLICE_W]  = wr_p;
                res_minus_d[k_q*SLICE_W +: SLICE_W] = wr_m;
                c1_d = sl_c1;
                c2_d = sl_c2;
                k_d  = last_slice ? '0 : k_q + 1'b1;
                if (last_slice) state_d = ST_DONE;
            end
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Accept is only possible from IDLE or a draining DONE.
        if (accept) begin
            state_d = ST_RUN;
            k_d     = '0;
            c1_d    = SD_ZERO_CARRY;
            c2_d    = SD_ZERO_CARRY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            c1_q        <= SD_ZERO_CARRY;
            c2_q        <= SD_ZERO_CARRY;
            res_plus_q  <= '0;
            res_minus_q <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            c1_q        <= c1_d;
            c2_q        <= c2_d;
            res_plus_q  <= res_plus_d;
            res_minus_q <= res_minus_d;
        end
    end

    // NOTE: operand registers are not reset; they are always loaded on accept before being read.
    always_ff @(posedge clk) begin
        ops_q <= ops_d;
    end

endmodule

// File: tb/tb_sd_slice_scheduler.sv
// Directed self-checking bench for sd_slice_scheduler with SLICES=2 (W=8).
module tb_sd_slice_scheduler;

    localparam int SLICES = 2;
    localparam int W      = 8;
    localparam int LAT    = SLICES;   // clock edges from accept edge to first DONE cycle

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a_plus = '0, a_minus = '0, b_plus = '0, b_minus = '0, r_plus = '0, r_minus = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] res_plus, res_minus;
    logic [1:0]   cout_one, cout_two;

    int vectors = 0;
    int miscompares = 0;

    sd_slice_scheduler #(.SLICES(SLICES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_plus    (a_plus),
        .a_minus   (a_minus),
        .b_plus    (b_plus),
        .b_minus   (b_minus),
        .r_plus    (r_plus),
        .r_minus   (r_minus),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res_plus  (res_plus),
        .res_minus (res_minus),
        .cout_one  (cout_one),
        .cout_two  (cout_two)
    );

    always #5 clk = ~clk;

    function automatic int c_val(input logic [1:0] c);
        return int'(c[1]) - int'(c[0]);
    endfunction

    function automatic int total();
        return int'(res_plus) - int'(res_minus) + 256 * (c_val(cout_one) + c_val(cout_two));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input logic [W-1:0] ap, am, bp, bm, rp, rm);
        a_plus = ap; a_minus = am; b_plus = bp; b_minus = bm; r_plus = rp; r_minus = rm;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
    endtask

    task automatic check_no_cancel_pairs(input string name);
`ifdef SD_SCHED_CANCEL_EN
        vectors++;
        if ((res_plus & res_minus) !== 8'h00 || cout_one === 2'b11 || cout_two === 2'b11) begin
            miscompares++;
            $display("FAIL %s_no11: res_plus=%h res_minus=%h cout_one=%b cout_two=%b", name,
                     res_plus, res_minus, cout_one, cout_two);
        end
`else
        if (name.len() < 0) $display("%s", name);
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        vectors++;
        if (res_plus !== 8'h00 || res_minus !== 8'h00) begin
            miscompares++; $display("FAIL reset_res: got %h/%h want 00/00", res_plus, res_minus);
        end
        vectors++;
        if (cout_one !== 2'b00 || cout_two !== 2'b00) begin
            miscompares++; $display("FAIL reset_cout: got %b/%b want 00/00", cout_one, cout_two);
        end
        rst_n = 1'b1;
        step();
    endtask

    // One full operation from IDLE: accept, latency, value, drain, hold in IDLE.
    task automatic run_op(input string name, input logic [W-1:0] ap, am, bp, bm, rp, rm, input int expv);
        int n;
        set_ops(ap, am, bp, bm, rp, rm);
        in_valid = 1'b1;
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL %s_in_ready: got %b want 1", name, in_ready); end
        step();
        in_valid = 1'b0;
        set_ops('0, '0, '0, '0, '0, '0);
        wait_valid(n);
        vectors++;
        if (n !== LAT) begin miscompares++; $display("FAIL %s_latency: got %0d edges want %0d", name, n, LAT); end
        vectors++;
        if (total() !== expv) begin miscompares++; $display("FAIL %s_value: got %0d want %0d", name, total(), expv); end
        check_no_cancel_pairs(name);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL %s_drain: out_valid got %b want 0", name, out_valid); end
        vectors++;
        if (total() !== expv) begin miscompares++; $display("FAIL %s_idle_hold: got %0d want %0d", name, total(), expv); end
    endtask

    task automatic test_add();
        run_op("add_5_3",     8'h05, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8);
        run_op("add_ff_1_1",  8'hFF, 8'h00, 8'h01, 8'h00, 8'h01, 8'h00, 257);
        run_op("add_neg16",   8'h00, 8'h10, 8'h01, 8'h00, 8'h00, 8'h01, -16);
        run_op("add_bothset", 8'hFF, 8'hFF, 8'h80, 8'h00, 8'h80, 8'h00, 256);
        run_op("add_allneg",  8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, -765);
    endtask

    task automatic test_backpressure();
        int n;
        set_ops(8'h05, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_valid(n);
        vectors++;
        if (n !== LAT) begin miscompares++; $display("FAIL bp_latency: got %0d want %0d", n, LAT); end
        for (int i = 0; i < 5; i++) begin
            set_ops(8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00);
            in_valid = 1'b1;
            #1;
            vectors++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || total() !== 8) begin
                miscompares++;
                $display("FAIL bp_hold_%0d: out_valid=%b in_ready=%b value=%0d want 1/0/8", i, out_valid, in_ready, total());
            end
            step();
        end
        set_ops(8'h10, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00);
        out_ready = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_ready_comb: got %b want 1", in_ready); end
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        set_ops('0, '0, '0, '0, '0, '0);
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_accept_drop: out_valid got %b want 0", out_valid); end
        wait_valid(n);
        vectors++;
        if (n !== LAT) begin miscompares++; $display("FAIL bp_next_latency: got %0d want %0d", n, LAT); end
        vectors++;
        if (total() !== 48) begin miscompares++; $display("FAIL bp_next_value: got %0d want 48", total()); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic load_b2b(input int i);
        case (i)
            0: set_ops(8'h7F, 8'h00, 8'h7F, 8'h00, 8'h7F, 8'h00);
            1: set_ops(8'h00, 8'h0F, 8'h00, 8'hF0, 8'h01, 8'h00);
            default: set_ops(8'hA5, 8'h5A, 8'h3C, 8'h00, 8'h00, 8'hC3);
        endcase
    endtask

    task automatic test_back_to_back();
        int n;
        int expv [3] = '{381, -254, 15};   // 127*3; -15-240+1; 75+60-195+75... see below
        // Third: (0xA5-0x5A) + 0x3C - 0xC3 = 75 + 60 - 195 = -60
        expv[2] = -60;
        out_ready = 1'b1;
        load_b2b(0);
        in_valid = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            if (i < 2) load_b2b(i + 1);
            else begin in_valid = 1'b0; set_ops('0, '0, '0, '0, '0, '0); end
            wait_valid(n);
            vectors++;
            if (n !== LAT) begin miscompares++; $display("FAIL b2b_%0d_period: got %0d want %0d", i, n, LAT); end
            vectors++;
            if (total() !== expv[i]) begin miscompares++; $display("FAIL b2b_%0d_value: got %0d want %0d", i, total(), expv[i]); end
            check_no_cancel_pairs("b2b");
            step();
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++; $display("FAIL b2b_end: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_in_run();
        set_ops(8'h05, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++; $display("FAIL rrun_state: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
        vectors++;
        if (res_plus !== 8'h00 || res_minus !== 8'h00 || cout_one !== 2'b00 || cout_two !== 2'b00) begin
            miscompares++;
            $display("FAIL rrun_values: res=%h/%h couts=%b/%b want zeros", res_plus, res_minus, cout_one, cout_two);
        end
        for (int i = 0; i < 6; i++) begin
            step();
            vectors++;
            if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rrun_no_valid_%0d: got %b want 0", i, out_valid); end
        end
        run_op("after_reset", 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h07, -5);
    endtask

    initial begin
        test_reset();
        test_add();
        test_backpressure();
        test_back_to_back();
        test_reset_in_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
